// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - frame constants, opcodes and FSM states shared by the MDIO master
package mdio_pkg;

  localparam logic [1:0] ST_C22       = 2'b01;
  localparam logic [1:0] ST_C45       = 2'b00;
  localparam logic [1:0] OP_C22_RD    = 2'b10;
  localparam logic [1:0] OP_C22_WR    = 2'b01;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RD    = 2'b11;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_GAP
  } mdio_state_e;

  // Frames whose TA/DATA phase is driven by the PHY rather than by us
  function automatic logic op_is_read(input logic c45, input logic [1:0] op);
    return c45 ? (op == OP_C45_RD || op == OP_C45_RDINC) : (op == OP_C22_RD);
  endfunction

endpackage

// File: rtl/mdio_clk_en.sv
// rtl/mdio_clk_en.sv - MDC divider with one-cycle rise/fall strobes; parked low when disabled
module mdio_clk_en #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt;
  logic       half_done;

  assign half_done = en && (div_cnt == 8'(CLK_DIV - 1));
  assign rise_stb  = half_done && !mdc;
  assign fall_stb  = half_done && mdc;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - command-driven MDIO management master; MDIO_C45_EN adds Clause 45 frames
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32,
  parameter int IDLE_GAP     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_C45_EN
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        MDC,
  inout  wire         MDIO
);

  mdio_state_e state, state_nxt;
  logic [6:0]  bit_cnt, cnt_nxt;
  logic [31:0] tx_sr;
  logic [14:0] rx_sr;
  logic        rd_q, ta_err, mdi_q;
  logic        mdo, mdo_oe, accept, rise_stb, fall_stb;
  logic [1:0]  st_sel, op_sel;
  logic        rd_sel;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign MDIO      = mdo_oe ? mdo : 1'bz;

`ifdef MDIO_C45_EN
  assign st_sel = cmd_c45 ? ST_C45 : ST_C22;
  assign op_sel = cmd_c45 ? cmd_op : (cmd_write ? OP_C22_WR : OP_C22_RD);
  assign rd_sel = op_is_read(cmd_c45, op_sel);
`else
  assign st_sel = ST_C22;
  assign op_sel = cmd_write ? OP_C22_WR : OP_C22_RD;
  assign rd_sel = op_is_read(1'b0, op_sel);
`endif

  mdio_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
    .clk      (CLK),
    .rst      (RST),
    .en       (busy),
    .mdc      (MDC),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Each state lasts bit_cnt+1 MDC periods; every bit boundary is a fall_stb
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    mdo       = 1'b1;
    mdo_oe    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (PREAMBLE_LEN > 0) begin
            state_nxt = S_PRE;
            cnt_nxt   = 7'(PREAMBLE_LEN - 1);
          end else begin
            state_nxt = S_HDR;
            cnt_nxt   = 7'(HDR_BITS - 1);
          end
        end
      end
      default: begin
        if (fall_stb) begin
          if (bit_cnt != 7'd0) begin
            cnt_nxt = bit_cnt - 7'd1;
          end else begin
            case (state)
              S_PRE:  begin state_nxt = S_HDR;  cnt_nxt = 7'(HDR_BITS - 1);  end
              S_HDR:  begin state_nxt = S_TA;   cnt_nxt = 7'(TA_BITS - 1);   end
              S_TA:   begin state_nxt = S_DATA; cnt_nxt = 7'(DATA_BITS - 1); end
              S_DATA: begin
                if (IDLE_GAP > 0) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = 7'(IDLE_GAP - 1);
                end else begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = 7'd0;
                end
              end
              default: begin state_nxt = S_IDLE; cnt_nxt = 7'd0; end
            endcase
          end
        end
      end
    endcase
    case (state)
      S_PRE:        mdo_oe = 1'b1;
      S_HDR:        begin mdo_oe = 1'b1;  mdo = tx_sr[31]; end
      S_TA, S_DATA: begin mdo_oe = !rd_q; mdo = tx_sr[31]; end
      default:      mdo_oe = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      rd_q      <= 1'b0;
      ta_err    <= 1'b0;
      mdi_q     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mdi_q     <= MDIO;
      rsp_valid <= 1'b0;
      if (accept) begin
        tx_sr <= {st_sel, op_sel, cmd_phy, cmd_reg, 2'b10, cmd_wdata};
        rd_q  <= rd_sel;
      end else if (fall_stb && (state == S_HDR || state == S_TA || state == S_DATA)) begin
        tx_sr <= {tx_sr[30:0], 1'b0};
      end
      if (rise_stb && rd_q) begin
        if (state == S_TA && bit_cnt == 7'd0) begin
          ta_err <= mdi_q;
        end
        if (state == S_DATA) begin
          rx_sr <= {rx_sr[13:0], mdi_q};
          if (bit_cnt == 7'd0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= {rx_sr, mdi_q};
            rsp_err   <= ta_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - randomized bench with a frame-level MDIO model and a responding PHY
module tb_mdio_master;

  localparam int D   = 4;
  localparam int PRE = 32;
  localparam int GAP = 1;
  localparam int FB  = PRE + 32;
  localparam int L   = 2 * D * (FB + GAP);
  localparam int RV  = (PRE + 31) * 2 * D + D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, c0_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0] cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy, MDC;
  logic [15:0] rsp_rdata;
  logic c0_ready, c0_rvalid, c0_err, busy0, mdc0;
  logic [15:0] c0_rdata;
  wire mdio, mdio0;
  logic phy_oe = 1'b0, phy_bit = 1'b0;

  assign mdio = phy_oe ? phy_bit : 1'bz;
  pullup (mdio);
  pullup (mdio0);

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PRE), .IDLE_GAP(GAP)) dut (
    .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
`ifdef MDIO_C45_EN
    .cmd_c45(1'b0), .cmd_op(2'b00),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .MDC(MDC), .MDIO(mdio)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0), .IDLE_GAP(0)) dut0 (
    .CLK(clk), .RST(rst), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
    .cmd_write(cmd_write), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
`ifdef MDIO_C45_EN
    .cmd_c45(1'b0), .cmd_op(2'b00),
`endif
    .rsp_valid(c0_rvalid), .rsp_rdata(c0_rdata), .rsp_err(c0_err),
    .busy(busy0), .MDC(mdc0), .MDIO(mdio0)
  );

  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: cycles since accept, the bit string the line should carry, pending response
  logic m_act = 1'b0, m_rd = 1'b0, m_nophy = 1'b0, m_rvalid = 1'b0, m_err = 1'b0;
  logic [FB-1:0] m_frame = '0;
  logic [15:0] m_data = '0, m_rdata = '0, nxt_data = '0;
  logic nxt_nophy = 1'b0, chk_en = 1'b0;
  int n = 0, m_acc = 0;

  function automatic logic exp_line(input int b);
    if (b >= FB) return 1'b1;
    if (!m_rd || b < PRE + 14) return m_frame[FB-1-b];
    if (b == PRE + 14 || m_nophy) return 1'b1;
    if (b == PRE + 15) return 1'b0;
    return m_data[15-(b-PRE-16)];
  endfunction

  initial forever begin
    @(posedge clk);
    m_rvalid = 1'b0;
    if (rst) begin
      m_act = 1'b0; m_rdata = '0; m_err = 1'b0;
    end else if (m_act) begin
      n++;
      if (n == L) m_act = 1'b0;
      if (m_rd && n == RV) begin
        m_rvalid = 1'b1;
        m_rdata  = m_nophy ? 16'hFFFF : m_data;
        m_err    = m_nophy;
      end
    end else if (cmd_valid) begin
      m_act = 1'b1; n = 0; m_rd = !cmd_write; m_data = nxt_data; m_nophy = nxt_nophy;
      m_frame = {{PRE{1'b1}}, 2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy, cmd_reg, 2'b10,
                 cmd_write ? cmd_wdata : 16'h0000};
      m_acc++;
    end
    #1;
    if (m_act && m_rd && !m_nophy && n / (2 * D) >= PRE + 15 && n / (2 * D) < FB) begin
      phy_bit = exp_line(n / (2 * D));
      phy_oe  = 1'b1;
    end else begin
      phy_oe = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", busy, m_act);
      chk("cmd_ready", cmd_ready, !m_act);
      chk("MDC", MDC, m_act && ((n / D) % 2 == 1));
      chk("MDIO", mdio, m_act ? exp_line(n / (2 * D)) : 1'b1);
      chk("rsp_valid", rsp_valid, m_rvalid);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (m_rvalid) chk("rsp_err", rsp_err, m_err);
    end
  end

  // Event monitors for the directed literal checks
  int cyc = 0, busy_cnt = 0, busy0_cnt = 0, vpulses = 0, t_prev = 0, t_last = 0;
  int rises = 0, rises0 = 0;
  logic last_err = 1'b0, ready_prev = 1'b1;
  logic [63:0] cap = '0;
  logic [31:0] cap0 = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (busy0) busy0_cnt++;
    if (rsp_valid) begin vpulses++; last_err = rsp_err; end
    if (ready_prev && !cmd_ready) begin t_prev = t_last; t_last = cyc; end
    ready_prev = cmd_ready;
  end
  always @(posedge MDC) begin
    if (rises < 64) cap[63-rises] = mdio;
    rises++;
  end
  always @(posedge mdc0) begin
    if (rises0 < 32) cap0[31-rises0] = mdio0;
    rises0++;
  end

  task automatic issue(input logic wr, input logic [4:0] p, input logic [4:0] r,
                       input logic [15:0] wd, input logic [15:0] pd, input logic np,
                       input logic hold);
    int acc0;
    cmd_write = wr; cmd_phy = p; cmd_reg = r; cmd_wdata = wd;
    nxt_data = pd; nxt_nophy = np; cmd_valid = 1'b1;
    acc0 = m_acc;
    for (int i = 0; i < 2 * L && m_acc == acc0; i++) begin
      @(posedge clk); #2;
    end
    if (m_acc == acc0) chk("accept_timeout", 64'd0, 64'd1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2 * L && m_act; i++) @(posedge clk);
    if (m_act) chk("idle_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    busy_cnt = 0; busy0_cnt = 0; vpulses = 0; rises = 0; rises0 = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_MDC", MDC, 1'b0);
    chk("rst_MDIO", mdio, 1'b1);
    chk_en = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk); #2;

    clr_mon();
    issue(1'b1, 5'h01, 5'h00, 16'h2100, 16'h0000, 1'b0, 1'b0);
    chk("model_frame", m_frame, 64'hFFFF_FFFF_5082_2100);
    wait_idle();
    chk("wr_bits", cap, 64'hFFFF_FFFF_5082_2100);
    chk("wr_busy_cycles", busy_cnt, 64'd520);
    chk("wr_mdc_rises", rises, 64'd65);
    chk("wr_no_rsp", vpulses, 64'd0);

    clr_mon();
    issue(1'b0, 5'h01, 5'h02, 16'h0000, 16'h0141, 1'b0, 1'b0);
    wait_idle();
    chk("rd_rdata", rsp_rdata, 16'h0141);
    chk("rd_err", last_err, 1'b0);
    chk("rd_pulses", vpulses, 64'd1);

    clr_mon();
    issue(1'b0, 5'h03, 5'h01, 16'h0000, 16'h1234, 1'b1, 1'b0);
    wait_idle();
    chk("nophy_rdata", rsp_rdata, 16'hFFFF);
    chk("nophy_err", last_err, 1'b1);
    chk("nophy_pulses", vpulses, 64'd1);

    clr_mon();
    issue(1'b1, 5'h04, 5'h09, 16'hA5C3, 16'h0000, 1'b0, 1'b1);
    issue(1'b0, 5'h04, 5'h09, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_accept_interval", t_last - t_prev, 64'd521);
    chk("b2b_rdata", rsp_rdata, 16'hBEEF);
    chk("b2b_pulses", vpulses, 64'd1);

    clr_mon();
    issue(1'b0, 5'h01, 5'h02, 16'h0000, 16'h5555, 1'b0, 1'b0);
    repeat (300) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_MDC", MDC, 1'b0);
    chk("midrst_MDIO", mdio, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("postrst_cmd_ready", cmd_ready, 1'b1);
    chk("postrst_rdata", rsp_rdata, 16'h0000);
    chk("midrst_no_rsp", vpulses, 64'd0);

    clr_mon();
    cmd_write = 1'b1; cmd_phy = 5'h01; cmd_reg = 5'h00; cmd_wdata = 16'h2100;
    @(posedge clk); #2 c0_valid = 1'b1;
    @(posedge clk); #2 c0_valid = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("nopre_bits", cap0, 32'h5082_2100);
    chk("nopre_busy_cycles", busy0_cnt, 64'd128);
    chk("nopre_mdc_rises", rises0, 64'd32);

    for (int k = 0; k < 24; k++) begin
      logic hold;
      hold = 1'($urandom_range(0, 1));
      issue(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
            16'($urandom), ($urandom_range(0, 5) == 0), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
